// File: rtl/regfile_rdport.sv
// Register file with DEPTH words of WIDTH bits, one write port and NRD registered read ports.
// Read latency is one cycle; a same-cycle write to the read address is forwarded (write-first).
// No backpressure: every asserted re is served on the next edge, with rvalid pulsing once per read.
module regfile_rdport #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [NRD-1:0]       i_re,
  input  logic [NRD*AW-1:0]    i_raddr,
  output logic [NRD*WIDTH-1:0] o_rdata,
  output logic [NRD-1:0]       o_rvalid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;

  // Writes to register 0 are discarded when it is hardwired to zero.
  assign w_wr_en = i_we && !((ZERO_R0 != 0) && (i_waddr == '0));

  // Storage array: cleared on reset, one write per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_dat;
    logic             r_vld;

    assign w_ra = i_raddr[gi*AW +: AW];

    // Operand select: hardwired zero beats forwarding, forwarding beats stored contents.
    always_comb begin
      w_sel = r_mem[w_ra];
      if (i_we && (i_waddr == w_ra)) begin
        w_sel = i_wdata;
      end
      if ((ZERO_R0 != 0) && (w_ra == '0)) begin
        w_sel = '0;
      end
    end

    // Output register: capture on read, otherwise hold data and drop valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_dat <= '0;
        r_vld <= 1'b0;
      end else begin
        r_vld <= i_re[gi];
        if (i_re[gi]) begin
          r_dat <= w_sel;
        end
      end
    end

    assign o_rdata[gi*WIDTH +: WIDTH] = r_dat;
    assign o_rvalid[gi]               = r_vld;
  end

endmodule

// File: tb/tb_regfile_rdport.sv
module tb_regfile_rdport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: WIDTH=8, DEPTH=32, NRD=2, ZERO_R0=0
  logic        a_we = 0;
  logic [4:0]  a_waddr = 0;
  logic [7:0]  a_wdata = 0;
  logic [1:0]  a_re = 0;
  logic [9:0]  a_raddr = 0;
  logic [15:0] a_rdata;
  logic [1:0]  a_rvalid;

  // Hardwired-zero instance
  logic        z_we = 0;
  logic [4:0]  z_waddr = 0;
  logic [7:0]  z_wdata = 0;
  logic [1:0]  z_re = 0;
  logic [9:0]  z_raddr = 0;
  logic [15:0] z_rdata;
  logic [1:0]  z_rvalid;

  // Wide, shallow, four-port instance
  logic        p_we = 0;
  logic [1:0]  p_waddr = 0;
  logic [15:0] p_wdata = 0;
  logic [3:0]  p_re = 0;
  logic [7:0]  p_raddr = 0;
  logic [63:0] p_rdata;
  logic [3:0]  p_rvalid;

  regfile_rdport #(.WIDTH(8), .DEPTH(32), .NRD(2), .ZERO_R0(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_we(a_we), .i_waddr(a_waddr), .i_wdata(a_wdata),
    .i_re(a_re), .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rvalid(a_rvalid));

  regfile_rdport #(.WIDTH(8), .DEPTH(32), .NRD(2), .ZERO_R0(1)) u_z (
    .i_clk(clk), .i_rst(rst), .i_we(z_we), .i_waddr(z_waddr), .i_wdata(z_wdata),
    .i_re(z_re), .i_raddr(z_raddr), .o_rdata(z_rdata), .o_rvalid(z_rvalid));

  regfile_rdport #(.WIDTH(16), .DEPTH(4), .NRD(4), .ZERO_R0(0)) u_p (
    .i_clk(clk), .i_rst(rst), .i_we(p_we), .i_waddr(p_waddr), .i_wdata(p_wdata),
    .i_re(p_re), .i_raddr(p_raddr), .o_rdata(p_rdata), .o_rvalid(p_rvalid));

  typedef struct {
    int          inst;
    int          port;
    logic [15:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_dat(input int inst, input int port);
    case (inst)
      0:       return {8'h00, a_rdata[port*8 +: 8]};
      1:       return {8'h00, z_rdata[port*8 +: 8]};
      default: return p_rdata[port*16 +: 16];
    endcase
  endfunction

  function automatic logic obs_vld(input int inst, input int port);
    case (inst)
      0:       return a_rvalid[port];
      1:       return z_rvalid[port];
      default: return p_rvalid[port];
    endcase
  endfunction

  // Drivers: write and read requests; reads push their expectation
  task automatic wr_a(input int addr, input logic [7:0] d);
    a_we = 1'b1; a_waddr = 5'(addr); a_wdata = d;
  endtask
  task automatic wr_z(input int addr, input logic [7:0] d);
    z_we = 1'b1; z_waddr = 5'(addr); z_wdata = d;
  endtask
  task automatic wr_p(input int addr, input logic [15:0] d);
    p_we = 1'b1; p_waddr = 2'(addr); p_wdata = d;
  endtask

  task automatic rd_a(input int port, input int addr, input logic [7:0] exp, input string tag);
    sb_t e;
    a_re[port] = 1'b1; a_raddr[port*5 +: 5] = 5'(addr);
    e.inst = 0; e.port = port; e.exp = {8'h00, exp}; e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic rd_z(input int port, input int addr, input logic [7:0] exp, input string tag);
    sb_t e;
    z_re[port] = 1'b1; z_raddr[port*5 +: 5] = 5'(addr);
    e.inst = 1; e.port = port; e.exp = {8'h00, exp}; e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic rd_p(input int port, input int addr, input logic [15:0] exp, input string tag);
    sb_t e;
    p_re[port] = 1'b1; p_raddr[port*2 +: 2] = 2'(addr);
    e.inst = 2; e.port = port; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock: sample just after the edge, idle the inputs, drain the scoreboard
  task automatic cyc();
    sb_t e;
    @(posedge clk);
    #1;
    a_we = 0; a_re = 0; z_we = 0; z_re = 0; p_we = 0; p_re = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs_dat(e.inst, e.port), e.exp);
      check({e.tag, "_vld"}, 16'(obs_vld(e.inst, e.port)), 16'd1);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rdata", a_rdata, 16'h0000);
    check("rst_rvalid", 16'(a_rvalid), 16'h0000);
    rst = 1'b0;

    // Load mem[5], read it back, then reset asynchronously between edges
    wr_a(5, 8'hA5); cyc();
    rd_a(0, 5, 8'hA5, "pre_rst_rd5"); cyc();
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", a_rdata, 16'h0000);
    check("async_rst_rvalid", 16'(a_rvalid), 16'h0000);
    #1 rst = 1'b0;
    rd_a(0, 5, 8'h00, "post_rst_rd5"); cyc();

    // Write then read, then hold with re low
    wr_a(7, 8'h3C); cyc();
    rd_a(0, 7, 8'h3C, "wr_then_rd7"); cyc();
    cyc();
    check("hold_rdata0", {8'h00, a_rdata[7:0]}, 16'h003C);
    check("hold_rvalid0", 16'(a_rvalid[0]), 16'h0000);

    // Same-cycle forwarding to both ports, then a plain read
    wr_a(9, 8'h11); cyc();
    wr_a(9, 8'h99);
    rd_a(0, 9, 8'h99, "fwd_p0");
    rd_a(1, 9, 8'h99, "fwd_p1");
    cyc();
    rd_a(0, 9, 8'h99, "after_fwd"); cyc();

    // Fill mem[i]=i*3, sweep ports in opposite directions
    for (int i = 0; i < 32; i++) begin
      wr_a(i, 8'(i * 3)); cyc();
    end
    for (int i = 0; i < 32; i++) begin
      rd_a(0, i, 8'(i * 3), $sformatf("sweep_p0_a%0d", i));
      rd_a(1, 31 - i, 8'((31 - i) * 3), $sformatf("sweep_p1_a%0d", 31 - i));
      cyc();
    end

    // Register 0: hardwired zero versus ordinary storage
    wr_a(0, 8'hFF); wr_z(0, 8'hFF); cyc();
    rd_a(0, 0, 8'hFF, "r0_plain_rd");
    rd_z(0, 0, 8'h00, "r0_zero_rd");
    cyc();
    wr_a(0, 8'hFF); wr_z(0, 8'hFF);
    rd_a(1, 0, 8'hFF, "r0_plain_fwd");
    rd_z(1, 0, 8'h00, "r0_zero_fwd");
    cyc();
    wr_z(1, 8'h5A); cyc();
    rd_z(0, 1, 8'h5A, "z_r1_normal"); cyc();

    // Four-port, 16-bit instance
    wr_p(3, 16'hBEEF); cyc();
    for (int i = 0; i < 4; i++) rd_p(i, 3, 16'hBEEF, $sformatf("p_rd3_port%0d", i));
    cyc();
    check("p_rvalid_all", 16'(p_rvalid), 16'h000F);
    wr_p(3, 16'h1234);
    for (int i = 0; i < 4; i++) rd_p(i, 3, 16'h1234, $sformatf("p_fwd3_port%0d", i));
    cyc();
    wr_p(0, 16'hCAFE); cyc();
    rd_p(0, 0, 16'hCAFE, "p_rd0"); rd_p(2, 3, 16'h1234, "p_rd3_after"); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_rdport.md
# regfile_rdport

Parametrised multi-port register file with registered, bypassed read ports: the next generation of the 32-entry, 8-bit, single-port combinational selector. It stores DEPTH words of WIDTH bits, accepts one write per cycle, and serves NRD independent read ports with one-cycle latency and write-to-read forwarding. It sits between the datapath write-back stage and the operand-fetch stage.

## Interface
- WIDTH, 8, bits per register
- DEPTH, 32, number of registers; power of two, 2..256
- AW, log2(DEPTH) = 5, address width
- NRD, 2, number of read ports, 1..4
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- re  in  NRD  per-port read enable; bit i controls port i
- raddr  in  NRD*AW  port i address at bits [i*AW +: AW]
- rdata  out  NRD*WIDTH  port i data at bits [i*WIDTH +: WIDTH], registered
- rvalid  out  NRD  bit i high for one cycle when port i's rdata updated

## Operation
- Storage: DEPTH x WIDTH flops. On rst, every entry clears to 0, rdata clears to 0, rvalid clears to 0.
- Write: on a rising clk edge with we=1, mem[waddr] <= wdata. When ZERO_R0=1 and waddr=0, the write is dropped.
- Read, per port i, independent of all other ports:
  - re[i]=1 at edge N: rdata_i <= selected value; rvalid[i] <= 1.
  - re[i]=0 at edge N: rdata_i holds its previous value; rvalid[i] <= 0.
- Selected value, in priority order:
  1. ZERO_R0=1 and raddr_i=0: 0.
  2. we=1 and waddr=raddr_i in the same cycle: wdata (write-first forwarding).
  3. Otherwise: mem[raddr_i] as it was before the edge.
- Any number of ports may read the same address in the same cycle. All of them return the same value.
- Address range: DEPTH is a power of two, so every raddr and waddr value is in range and no wrap logic is needed.
- The output is a full case or index over DEPTH. There is no latch and no sensitivity to sel only: rdata follows both the contents and the address.

## Timing
- Read latency is 1 cycle: address and re are sampled at edge N, and rdata/rvalid are valid after edge N until edge N+1.
- Write-to-read latency:
  - Same-cycle write and read of one address returns new data at edge N (forwarded).
  - A read issued at edge N+1 or later returns the stored data.
- rvalid is a single-cycle pulse per accepted read. Back-to-back reads keep rvalid high continuously.
- Reset is asynchronous:
  - Asserting rst mid-operation clears memory and outputs immediately, without waiting for clk.
  - While rst=1, writes and reads are ignored.
  - The first operation is sampled on the first rising edge after rst deasserts.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset: load mem[5]=0xA5, then assert rst between edges -> rdata=0 and rvalid=0 immediately. A read of address 5 after release returns 0x00.
- Write then read: write 0x3C to address 7 at edge 1; port 0 reads address 7 at edge 2 -> rdata_0=0x3C and rvalid[0]=1 after edge 2. With re[0]=0 at edge 3 -> rdata_0 holds 0x3C and rvalid[0]=0.
- Forwarding: mem[9]=0x11; at one edge write 0x99 to address 9 while port 0 and port 1 both read address 9 -> both return 0x99. A read at the next edge also returns 0x99.
- Independent ports: fill mem[i]=i*3 for all 32 entries; port 0 sweeps 0..31 while port 1 sweeps 31..0 -> each output matches i*3 one cycle after its address. Check the endpoint addresses 0 and 31.
- ZERO_R0=1: write 0xFF to address 0, then read address 0 -> 0x00, including a same-cycle forwarding attempt. With ZERO_R0=0, the same sequence returns 0xFF.
- Parameter sweep: WIDTH=16, DEPTH=4, NRD=4; all ports read address 3 after writing 0xBEEF -> all four rdata slices equal 0xBEEF and rvalid=4'b1111.
